// File: rtl/platform_pkg.sv
// Shared constants and types for the platform line renderer.
// PLATFORM_TEXTURE_EN adds the per-entry row field used for texture addressing.
package platform_pkg;

    localparam int unsigned NUM_SLOTS    = 7;
    localparam int unsigned MAX_PER_LINE = 4;
    localparam int unsigned PLAT_W       = 60;
    localparam int unsigned PLAT_H       = 16;
    localparam int unsigned SCREEN_W     = 640;

    localparam int unsigned IDX_W = 3;
    localparam int unsigned ENT_W = $clog2(MAX_PER_LINE);
    localparam int unsigned CNT_W = $clog2(MAX_PER_LINE + 1);

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       active;
    } plat_slot_t;

    typedef struct packed {
        logic       valid;
        logic [9:0] x;
`ifdef PLATFORM_TEXTURE_EN
        logic [3:0] row;
`endif
    } line_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } render_state_t;

endpackage

// File: rtl/plat_line_buffer.sv
// Scan/display double buffer: hits append into the scan side during blanking,
// and a new scan either promotes the scan side to display or empties the display.
module plat_line_buffer
    import platform_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            keep,
    input  logic                            append,
    input  line_entry_t                     entry,
    output line_entry_t [MAX_PER_LINE-1:0]  disp,
    output logic                            overflow
);

    line_entry_t [MAX_PER_LINE-1:0] scan;
    logic [CNT_W-1:0]               count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan     <= '0;
            disp     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (start) begin
            // An aborted scan leaves a partial buffer, so the display line goes blank instead.
            if (keep) begin
                disp <= scan;
            end else begin
                disp <= '0;
            end
            scan  <= '0;
            count <= '0;
        end else if (append) begin
            if (count < CNT_W'(MAX_PER_LINE)) begin
                scan[count[ENT_W-1:0]] <= entry;
                count                  <= count + 1'b1;
            end else begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/platform_line_renderer.sv
// Scans the platform slot table each blanking period and draws the hits on the next line.
// Build option: PLATFORM_TEXTURE_EN enables the {row,col} texture ROM address.
module platform_line_renderer
    import platform_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        line_start,
    input  logic [9:0]  line_y,
    input  logic [9:0]  DrawX,
    input  logic        draw_en,
    output logic        tbl_req,
    output logic [2:0]  tbl_idx,
    input  logic        tbl_ack,
    input  logic [9:0]  tbl_x,
    input  logic [9:0]  tbl_y,
    input  logic        tbl_active,
    output logic        is_platform,
    output logic [9:0]  plat_rom_addr,
    output logic        scan_abort,
    output logic        overflow
);

    render_state_t state, state_nxt;
    logic          req_nxt;
    logic [2:0]    idx_nxt;
    logic [9:0]    line_r, line_nxt;
    logic          abort_nxt;
    logic          buf_start, buf_keep, buf_append;

    plat_slot_t                     slot;
    line_entry_t                    new_entry;
    line_entry_t [MAX_PER_LINE-1:0] disp;
    logic [10:0]                    d;
    logic                           row_hit;

    assign slot    = '{x: tbl_x, y: tbl_y, active: tbl_active};
    // Borrow out of the 11-bit difference means the slot lies below the line: no wrap.
    assign d       = {1'b0, line_r} - {1'b0, slot.y};
    assign row_hit = slot.active && !d[10] && (d[9:0] < 10'(PLAT_H));

    always_comb begin
        new_entry       = '0;
        new_entry.valid = 1'b1;
        new_entry.x     = slot.x;
`ifdef PLATFORM_TEXTURE_EN
        new_entry.row   = d[3:0];
`endif
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            tbl_req    <= 1'b0;
            tbl_idx    <= '0;
            line_r     <= '0;
            scan_abort <= 1'b0;
        end else begin
            state      <= state_nxt;
            tbl_req    <= req_nxt;
            tbl_idx    <= idx_nxt;
            line_r     <= line_nxt;
            scan_abort <= abort_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_nxt    = tbl_req;
        idx_nxt    = tbl_idx;
        line_nxt   = line_r;
        abort_nxt  = scan_abort;
        buf_start  = 1'b0;
        buf_keep   = 1'b0;
        buf_append = 1'b0;
        if (line_start) begin
            buf_start = 1'b1;
            buf_keep  = (state != REQ);
            abort_nxt = scan_abort | (state == REQ);
            line_nxt  = line_y;
            idx_nxt   = '0;
            req_nxt   = 1'b1;
            state_nxt = REQ;
        end else begin
            case (state)
                IDLE: state_nxt = IDLE;
                REQ: begin
                    // The request drops for one cycle after each ack so every slot is a fresh handshake.
                    if (tbl_req && tbl_ack) begin
                        buf_append = row_hit;
                        req_nxt    = 1'b0;
                        if (tbl_idx == IDX_W'(NUM_SLOTS - 1)) begin
                            state_nxt = DONE;
                        end else begin
                            idx_nxt = tbl_idx + 3'd1;
                        end
                    end else begin
                        req_nxt = 1'b1;
                    end
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    plat_line_buffer u_buf (
        .clk      (Clk),
        .rst_n    (Reset_n),
        .start    (buf_start),
        .keep     (buf_keep),
        .append   (buf_append),
        .entry    (new_entry),
        .disp     (disp),
        .overflow (overflow)
    );

    logic [MAX_PER_LINE-1:0] in_span;
    logic                    pix_hit;
`ifdef PLATFORM_TEXTURE_EN
    logic [10:0]             col [MAX_PER_LINE];
    logic [9:0]              pix_addr;

    always_comb begin
        in_span = '0;
        for (int unsigned e = 0; e < MAX_PER_LINE; e++) begin
            col[e]     = {1'b0, DrawX} - {1'b0, disp[e].x};
            in_span[e] = !col[e][10] && (col[e][9:0] < 10'(PLAT_W));
        end
    end
`else
    always_comb begin
        in_span = '0;
        for (int unsigned e = 0; e < MAX_PER_LINE; e++) begin
            in_span[e] = (DrawX >= disp[e].x) &&
                         ({1'b0, DrawX} < ({1'b0, disp[e].x} + 11'(PLAT_W)));
        end
    end
`endif

    // Lowest buffer entry wins where platforms overlap.
    always_comb begin
        pix_hit = 1'b0;
`ifdef PLATFORM_TEXTURE_EN
        pix_addr = '0;
`endif
        for (int unsigned e = 0; e < MAX_PER_LINE; e++) begin
            if (!pix_hit && draw_en && (DrawX < 10'(SCREEN_W)) && disp[e].valid && in_span[e]) begin
                pix_hit = 1'b1;
`ifdef PLATFORM_TEXTURE_EN
                pix_addr = {disp[e].row, col[e][5:0]};
`endif
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            is_platform <= 1'b0;
        end else begin
            is_platform <= pix_hit;
        end
    end

`ifdef PLATFORM_TEXTURE_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            plat_rom_addr <= '0;
        end else begin
            plat_rom_addr <= pix_addr;
        end
    end
`else
    assign plat_rom_addr = '0;
`endif

endmodule
